// File: rtl/stringtransmitter.sv
// Serial frame transmitter: shifts a frame out LSB-first and counts
// overlapping occurrences of a pattern, giving a reference count for detectors.
module stringtransmitter #(
  parameter int FRAME_W = 20,
  parameter int PAT_W   = 4,
  parameter int GAP     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  input  logic [PAT_W-1:0]   pattern,
  output logic               serial_out,
  output logic               frame_valid,
  output logic               busy,
  output logic               done,
  output logic [4:0]         expected_n
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] FIRST_WIN = CNT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         match_q, match_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               serial_q, serial_d;
  logic               fv_q, fv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [4:0]         expn_q, expn_d;
  logic [PAT_W-1:0]   win_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      pat_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      match_q  <= '0;
      gap_q    <= '0;
      serial_q <= 1'b0;
      fv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      expn_q   <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      pat_q    <= pat_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      gap_q    <= gap_d;
      serial_q <= serial_d;
      fv_q     <= fv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      expn_q   <= expn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    gap_d     = gap_q;
    serial_d  = serial_q;
    fv_d      = fv_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    expn_d    = expn_q;
    // Bit on the line this cycle enters at the MSB, so the newest bit is the window's top.
    win_shift = {shreg_q[0], win_q[PAT_W-1:1]};

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b0;
        fv_d     = 1'b0;
        busy_d   = 1'b0;
        if (start) begin
          shreg_d  = frame;
          pat_d    = pattern;
          win_d    = '0;
          cnt_d    = '0;
          match_d  = '0;
          serial_d = frame[0];
          fv_d     = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        win_d   = win_shift;
        cnt_d   = cnt_q + 1'b1;
        shreg_d = shreg_q >> 1;
        if (cnt_q >= FIRST_WIN && win_shift == pat_q) begin
          match_d = match_q + 5'd1;
        end
        if (cnt_q == LAST_BIT) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          expn_d   = match_d;
          serial_d = 1'b0;
          fv_d     = 1'b0;
        end else begin
          serial_d = shreg_q[1];
        end
      end
      S_DONE: begin
        serial_d = 1'b0;
        fv_d     = 1'b0;
        if (GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_GAP: begin
        serial_d = 1'b0;
        fv_d     = 1'b0;
        if (gap_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign serial_out  = serial_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign expected_n  = expn_q;

endmodule
